// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles the signals between the CPU ports, the arbiter and the memory model.
//   Fetch port : if_req, if_addr -> ; <- if_rdata, if_ack
//   Data port  : d_req, d_we, d_addr, d_wdata -> ; <- d_rdata, d_ack
//   Memory     : <- mem_req, mem_we, mem_addr, mem_wdata ; mem_rdata, mem_ready ->
//
// Handshake rules:
//   A requester raises x_req and holds its address/data stable until it sees
//   x_ack for one cycle. The arbiter raises mem_req and holds mem_we, mem_addr
//   and mem_wdata stable until the memory returns mem_ready. mem_ready may
//   already be high in the first mem_req cycle, and mem_rdata is valid
//   whenever mem_ready is high.
//
// Modports:
//   slave  - arbiter view (takes requests, drives acks and the memory side)
//   master - environment view (CPU requesters plus the memory model)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch port
// and the data load/store port. Requests are serialised one at a time; data
// wins ties, except that fetch is forced once MAX_DSTREAK consecutive data
// grants have been made while a fetch was pending. Every completed transfer
// returns a one-cycle ack on the port that issued it.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous reset, active low
//   bus        ifc  mem_port_arbiter_if.slave (fetch, data and memory sides)
//   busy       out  1 while a transfer is granted (state != IDLE)
//   err        out  one-cycle timeout pulse (constant 0 without ARB_TIMEOUT_EN)
//   state_dbg  out  current FSM state (0 IDLE, 1 GNT_I, 2 GNT_D)
//
// Build option:
//   ARB_TIMEOUT_EN - when defined, a transfer that sees no mem_ready for
//   TIMEOUT_CYCLES cycles is completed anyway with rdata 32'hDEADBEEF and a
//   one-cycle err pulse. When undefined the arbiter waits on mem_ready
//   indefinitely.
//
// Latency: request seen in cycle N with the memory ready at once gives
// mem_req in N+1 and the ack in N+2; back-to-back transfers take 2 cycles each.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DSTREAK    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           state_dbg
);

    // Parameter sanity, caught at elaboration.
    generate
        if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("mem_port_arbiter: MAX_DSTREAK must be 1..15 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t            state;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic              err_q;
    logic [3:0]        dstreak;

    logic              i_elig;
    logic              d_elig;
    logic              pick_i;
    logic              timeout_hit;
    logic              done;
    logic [DATA_W-1:0] rsp_data;
    logic [3:0]        dstreak_inc;

    // A requester whose ack is high this cycle is masked, so a req that is
    // still high in the ack cycle is not mistaken for a new request.
    assign i_elig = bus.if_req & ~if_ack_q;
    assign d_elig = bus.d_req  & ~d_ack_q;

    // Data has priority unless the streak guard has saturated.
    assign pick_i = i_elig & (~d_elig | (dstreak == 4'(MAX_DSTREAK)));

    assign dstreak_inc = (dstreak == 4'(MAX_DSTREAK)) ? dstreak : dstreak + 4'd1;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Counts cycles spent in a grant state; held at 0 in IDLE so every new
    // grant starts from zero. mem_ready in the limit cycle takes precedence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state != IDLE) & ~bus.mem_ready &
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_data    = timeout_hit ? DATA_W'(32'hDEADBEEF) : bus.mem_rdata;
`else
    assign timeout_hit = 1'b0;
    assign rsp_data    = bus.mem_rdata;
`endif

    assign done = bus.mem_ready | timeout_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            dstreak     <= 4'd0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_i) begin
                        state       <= GNT_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        dstreak     <= 4'd0;
                    end else if (d_elig) begin
                        state       <= GNT_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        // The streak only grows while fetch is actually waiting.
                        dstreak     <= bus.if_req ? dstreak_inc : 4'd0;
                    end
                end
                GNT_I: begin
                    if (done) begin
                        state      <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= rsp_data;
                        err_q      <= timeout_hit;
                    end
                end
                GNT_D: begin
                    if (done) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        d_ack_q   <= 1'b1;
                        err_q     <= timeout_hit;
                        if (!mem_we_q) begin
                            d_rdata_q <= rsp_data;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;

    assign busy      = (state != IDLE);
    assign err       = err_q;
    assign state_dbg = state;

endmodule
